// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_if
// Description : Signal bundle between a boot byte source / instruction memory
//               and the instruction loader.
//   slave  modport : loader side (consumes bytes, produces writes + status)
//   master modport : source side (drives start and the byte stream)
//   Signals:
//     start      one-cycle load request
//     rx_data    incoming byte            rx_valid  byte present
//     rx_ready   loader accepts a byte this cycle
//     we/waddr/wdata  instruction-memory write port
//     cpu_reset  holds the CPU in reset (low only after a good load)
//     busy/done/error  load status
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_loader_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  start;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [15:0]           wdata;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, we, waddr, wdata, cpu_reset, busy, done, error
  );

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata, cpu_reset, busy, done, error
  );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Boot-time writer for the Hack instruction memory. Receives a
//               big-endian length N followed by N 16-bit words (high byte
//               first) over a byte valid/ready stream and writes them to
//               consecutive addresses from 0. Keeps the CPU in reset until a
//               load completes successfully.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset
//     bus    instr_loader_if.slave: start, rx_data/rx_valid/rx_ready,
//            we/waddr/wdata, cpu_reset, busy, done, error
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic           clk,
  input  logic           reset,
  instr_loader_if.slave  bus
);

  // Counter is one bit wider than the address so N == DEPTH fits.
  localparam int          CW      = ADDR_WIDTH + 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t          state;
  logic [15:0]     len;
  logic [CW-1:0]   cnt;

  // rx_ready is a registered copy of "state is a receive state", so a
  // transfer can be qualified directly from it.
  logic            take;
  logic [15:0]     len_next;
  logic [15:0]     cnt_ext;
  logic            last_word;

  assign take      = bus.rx_valid & bus.rx_ready;
  // Length as it will be once the low byte currently on rx_data is taken.
  assign len_next  = {len[15:8], bus.rx_data};
  assign cnt_ext   = 16'(cnt);
  assign last_word = ((cnt_ext + 16'd1) == len);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      len           <= '0;
      cnt           <= '0;
      bus.rx_ready  <= 1'b0;
      bus.we        <= 1'b0;
      bus.waddr     <= '0;
      bus.wdata     <= '0;
      bus.cpu_reset <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // Any byte presented alongside start is not consumed: rx_ready
          // is low in these states.
          if (bus.start) begin
            state         <= S_LEN_HI;
            bus.rx_ready  <= 1'b1;
            bus.busy      <= 1'b1;
            bus.cpu_reset <= 1'b1;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
          end
        end

        S_LEN_HI: begin
          if (take) begin
            len[15:8] <= bus.rx_data;
            state     <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (take) begin
            len[7:0] <= bus.rx_data;
            if (len_next == 16'd0) begin
              state         <= S_DONE;
              bus.rx_ready  <= 1'b0;
              bus.busy      <= 1'b0;
              bus.cpu_reset <= 1'b0;
              bus.done      <= 1'b1;
            end else if ({1'b0, len_next} > DEPTH_W) begin
              state         <= S_ERR;
              bus.rx_ready  <= 1'b0;
              bus.busy      <= 1'b0;
              bus.error     <= 1'b1;
            end else begin
              cnt   <= '0;
              state <= S_DATA_HI;
            end
          end
        end

        S_DATA_HI: begin
          if (take) begin
            bus.wdata[15:8] <= bus.rx_data;
            state           <= S_DATA_LO;
          end
        end

        S_DATA_LO: begin
          if (take) begin
            bus.wdata[7:0] <= bus.rx_data;
            // Strobe and address are registered here so they appear
            // together during the single WRITE cycle.
            bus.we         <= 1'b1;
            bus.waddr      <= cnt[ADDR_WIDTH-1:0];
            bus.rx_ready   <= 1'b0;
            state          <= S_WRITE;
          end
        end

        S_WRITE: begin
          cnt <= cnt + CW'(1);
          if (last_word) begin
            // DONE follows the final write on the very next edge, so the
            // CPU leaves reset only after the last word is in memory.
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.cpu_reset <= 1'b0;
            bus.done      <= 1'b1;
          end else begin
            state        <= S_DATA_HI;
            bus.rx_ready <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Self-checking bench for instr_loader. Stimulus pushes the
//               expected {waddr, wdata} of every write into a queue; a
//               monitor pops and compares on each we pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instr_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [26:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got waddr %0h wdata %0h expected no write",
                 bus.waddr, bus.wdata);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        check("waddr", 32'(bus.waddr), 32'(e[26:16]));
        check("wdata", 32'(bus.wdata), 32'(e[15:0]));
      end
    end
  end

  // Called at #1 after a posedge; returns #1 after the start edge.
  task automatic start_load();
    bus.start    = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles; returns #1 after the
  // accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    logic acc;
    for (int i = 0; i < gap; i++) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    do begin
      acc = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) check("rx_accept_timeout", 32'(acc), 32'd1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_load(input logic [15:0] n, input logic [15:0] words[$], input int gapmax);
    send_byte(n[15:8], $urandom_range(0, gapmax));
    send_byte(n[7:0],  $urandom_range(0, gapmax));
    for (int i = 0; i < words.size(); i++) begin
      exp_q.push_back({AW'(i), words[i]});
      send_byte(words[i][15:8], $urandom_range(0, gapmax));
      send_byte(words[i][7:0],  $urandom_range(0, gapmax));
    end
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(bus.done || bus.error) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(bus.done || bus.error)) check("end_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w[$];

    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_rx_ready",  32'(bus.rx_ready),  32'd0);
    check("rst_we",        32'(bus.we),        32'd0);
    check("rst_waddr",     32'(bus.waddr),     32'd0);
    check("rst_wdata",     32'(bus.wdata),     32'd0);
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_error",     32'(bus.error),     32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Two-word back-to-back load with DONE timing
    start_load();
    check("lenhi_busy",  32'(bus.busy),     32'd1);
    check("lenhi_ready", 32'(bus.rx_ready), 32'd1);
    w = '{16'hABCD, 16'h1234};
    fork
      send_load(16'd2, w, 0);
      begin
        repeat (7) @(posedge clk);
        #1;
        check("t7_done",      32'(bus.done),      32'd0);
        check("t7_busy",      32'(bus.busy),      32'd1);
        check("t7_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        @(posedge clk); #1;
        check("t8_done",      32'(bus.done),      32'd1);
        check("t8_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        check("t8_busy",      32'(bus.busy),      32'd0);
      end
    join

    // Zero-length load, then bytes offered in DONE must be ignored
    start_load();
    check("restart_done_clr", 32'(bus.done),      32'd0);
    check("restart_cpu_rst",  32'(bus.cpu_reset), 32'd1);
    w = {};
    send_load(16'd0, w, 0);
    check("zero_done",      32'(bus.done),      32'd1);
    check("zero_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    check("done_ready", 32'(bus.rx_ready), 32'd0);
    check("done_stay",  32'(bus.done),     32'd1);
    bus.rx_valid = 1'b0;

    // Oversize length -> ERR, then recover
    start_load();
    send_load(16'h0801, w, 0);
    check("err_error",     32'(bus.error),     32'd1);
    check("err_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("err_done",      32'(bus.done),      32'd0);
    check("err_busy",      32'(bus.busy),      32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 32'(bus.error), 32'd1);
    start_load();
    check("err_clr", 32'(bus.error), 32'd0);
    w = '{16'h5AA5};
    send_load(16'd1, w, 0);
    wait_end(20);
    check("recover_done",  32'(bus.done),  32'd1);
    check("recover_error", 32'(bus.error), 32'd0);

    // Full-depth load, word == address
    start_load();
    w = {};
    for (int i = 0; i < DEPTH; i++) w.push_back(16'(i));
    send_load(16'h0800, w, 0);
    wait_end(20);
    check("full_done",      32'(bus.done),      32'd1);
    check("full_last_addr", 32'(bus.waddr),     32'h7FF);
    check("full_last_data", 32'(bus.wdata),     32'h07FF);
    check("full_cpu_reset", 32'(bus.cpu_reset), 32'd0);

    // Three words with random rx_valid gaps
    start_load();
    w = '{16'hC0DE, 16'h0BAD, 16'hF00D};
    send_load(16'd3, w, 3);
    wait_end(20);
    check("gap_done", 32'(bus.done), 32'd1);

    // Reset after the HI byte of word 1
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    exp_q.push_back({AW'(0), 16'h1357});
    send_byte(8'h13, 0);
    send_byte(8'h57, 0);
    send_byte(8'h24, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_we",        32'(bus.we),        32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("abort_ready",     32'(bus.rx_ready),  32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start_load();
    w = '{16'hBEEF};
    send_load(16'd1, w, 0);
    wait_end(20);
    check("fresh_done", 32'(bus.done), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_loader.md
# instr_loader

Boot-time writer for the Hack instruction memory. Receives a length-prefixed stream of 16-bit Hack words over a byte-wide valid/ready interface (typically fed by a UART receiver) and writes them to consecutive instruction-memory addresses starting at 0. Holds the CPU in reset while loading and releases it on successful completion. It is the write-side counterpart of the read-only instruction memory fetch path.

## Interface

Parameters:
- ADDR_WIDTH, 11, instruction-memory address width.
- DEPTH, 2048, number of 16-bit words; the maximum legal length.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data holds a valid byte.
- rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
- we  output  1  instruction-memory write strobe, one cycle per word.
- waddr  output  ADDR_WIDTH  write address.
- wdata  output  16  write data.
- cpu_reset  output  1  holds the CPU in reset; low only in DONE.
- busy  output  1  a load is in progress.
- done  output  1  the load completed; sticky until the next start or reset.
- error  output  1  the length field exceeded DEPTH; sticky until the next start or reset.

## Operation

- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words, each sent high byte first.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
- IDLE -> LEN_HI on start. In IDLE, cpu_reset = 1.
- LEN_HI: accept a byte into len[15:8], then go to LEN_LO.
- LEN_LO: accept a byte into len[7:0]. Then:
  - N == 0 -> DONE.
  - N > DEPTH -> ERR.
  - otherwise clear the word counter and go to DATA_HI.
- DATA_HI: accept a byte into wdata[15:8], then go to DATA_LO.
- DATA_LO: accept a byte into wdata[7:0], then go to WRITE.
- WRITE, one cycle:
  - we = 1; waddr = word counter; increment the counter.
  - If this was word N (counter == N-1 before the increment) -> DONE, else -> DATA_HI.
- DONE: cpu_reset = 0, done = 1. start -> LEN_HI, which clears done and reasserts cpu_reset the next cycle.
- ERR: cpu_reset = 1, error = 1. Remains until start or reset.
- rx_ready = 1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO; 0 in all other states.
- busy = 1 in LEN_HI through WRITE.
- Bytes presented while rx_ready = 0 are not consumed.
- start while busy is ignored.
- Word counter width: ADDR_WIDTH+1 bits, so N == DEPTH is representable. waddr = counter[ADDR_WIDTH-1:0]; no wrap-around occurs because N ≤ DEPTH.
- wdata holds its value between writes; it is valid whenever we = 1.

## Timing

- Reset values: state IDLE, rx_ready 0, we 0, waddr 0, wdata 0, cpu_reset 1, busy 0, done 0, error 0; length and counter 0.
- Reset asserted mid-load aborts immediately, the next edge is in IDLE, and no further we is issued. Memory contents already written are left as they are.
- Each accepted byte costs exactly one cycle when rx_valid is held high, so a word takes 3 cycles (HI, LO, WRITE).
- Minimum load time with rx_valid continuously high: 2 + 3N cycles from the first LEN_HI cycle to entering DONE.
- we rises the cycle after the LO byte is accepted.
- The last write and the entry into DONE are on consecutive edges, so cpu_reset deasserts one cycle after the final we. The CPU therefore never fetches before the last word is written.
- Gaps in rx_valid only stretch the receive states; no timeout.
- start and rx_valid in the same cycle while in IDLE: only the state change happens; the byte is not consumed.

## Test plan

- Reset, then start, then stream 00 02 AB CD 12 34 with rx_valid held high -> we pulses at waddr 0 with wdata ABCD and at waddr 1 with wdata 1234. done = 1 and cpu_reset = 0 eight cycles after the first LEN_HI cycle.
- Stream 00 00 -> DONE directly with no we pulse.
- Stream 08 01 (N = 2049) -> ERR, error = 1, cpu_reset = 1, no we. A following start plus a valid stream then loads normally and clears error.
- Full load, N = 2048 (08 00), with words equal to their address -> the last write is at waddr 7FF with wdata 07FF, followed by done.
- Random rx_valid gaps during a 3-word load -> the same writes as the back-to-back case. rx_data values presented while rx_ready = 0 are never captured.
- Reset asserted after the HI byte of word 1 -> IDLE on the next cycle, with we = 0, busy = 0 and cpu_reset = 1. A fresh load then starts writing again at waddr 0.
